// File: rtl/dmem_ctrl_if.sv
// rtl/dmem_ctrl_if.sv - word-bus interface between dmem_ctrl and the memory system
//
// Signals:
//   bus_req    request, held until the cycle bus_ack is seen
//   bus_we     1=write, 0=read
//   bus_addr   word address
//   bus_wdata  write data
//   bus_be     byte enables
//   bus_ack    accept/complete from the memory side
//   bus_rdata  read data, valid with bus_ack
// Modports: master (controller side), slave (memory side).
interface dmem_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - data-memory controller with posted-store write buffer
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   mem_read          load request (level, held until mem_done)
//   mem_write         store request (one store per high cycle)
//   mem_addr          byte address
//   mem_wdata         lane-replicated store data
//   opcode            LB=20 LH=21 LW=22 LBU=23 LHU=24 SB=25 SH=26 SW=27
//   mem_done          one-cycle load-complete pulse
//   mem_rdata         right-justified load data, valid with mem_done
//   misalign          one-cycle misaligned-access pulse
//   wb_overflow       sticky: a store was dropped because the buffer was full
//   bus               word bus (master modport), all outputs registered
module dmem_ctrl #(
    parameter int WB_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [7:0]        opcode,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic              misalign,
    output logic              wb_overflow,
    dmem_ctrl_if.master       bus
);
    localparam int AW    = $clog2(WB_DEPTH);
    localparam int CNT_W = AW + 1;

    localparam logic [7:0] OP_LB = 8'd20, OP_LH = 8'd21, OP_LW = 8'd22, OP_LBU = 8'd23;
    localparam logic [7:0] OP_LHU = 8'd24, OP_SB = 8'd25, OP_SH = 8'd26, OP_SW = 8'd27;

    typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;
    state_t state, state_nxt;

    // FIFO entry layout: {word addr[31:0], wdata[31:0], be[3:0]}
    logic [67:0]      fifo_mem [WB_DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic             full, push, pop, ovf_set;
    logic [67:0]      push_entry, head, head_next;

    logic             half_op, word_op, mis;
    logic [3:0]       st_be;
    logic             ld_go, ld_mis, bus_ack_v;

    logic [7:0]       ld_op;
    logic [1:0]       ld_lsb;
    logic [31:0]      sh_b, sh_h, ld_data;

    assign half_op = (opcode == OP_LH) || (opcode == OP_LHU) || (opcode == OP_SH);
    assign word_op = (opcode == OP_LW) || (opcode == OP_SW);
    assign mis     = (half_op && mem_addr[0]) || (word_op && (mem_addr[1:0] != 2'b00));

    always_comb begin
        st_be = 4'b0000;
        case (opcode)
            OP_SB:   st_be = 4'b0001 << mem_addr[1:0];
            OP_SH:   st_be = 4'b0011 << {mem_addr[1], 1'b0};
            OP_SW:   st_be = 4'b1111;
            default: st_be = 4'b0000;
        endcase
    end

    // bus_ack only counts while a request is actually outstanding
    assign bus_ack_v  = bus.bus_req && bus.bus_ack;
    assign full       = (count == CNT_W'(WB_DEPTH));
    assign pop        = (state == WR) && bus_ack_v;
    assign push       = mem_write && !mis && (!full || pop);
    assign ovf_set    = mem_write && !mis && full && !pop;
    assign push_entry = {mem_addr[31:2], 2'b00, mem_wdata, st_be};
    assign head       = fifo_mem[rd_ptr];
    // When only one entry remains and a store lands on the pop edge, the new
    // head is still being written, so forward it straight from the inputs.
    assign head_next  = (count > CNT_W'(1)) ? fifo_mem[rd_ptr + AW'(1)] : push_entry;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ld_go     = 1'b0;
        ld_mis    = 1'b0;
        case (state)
            IDLE: begin
                // Buffered stores always drain first; a load coinciding with a
                // store waits so it cannot overtake it.
                if (count != '0) begin
                    state_nxt = WR;
                end else if (mem_read && !mem_write) begin
                    if (mis) begin
                        state_nxt = DONE;
                        ld_mis    = 1'b1;
                    end else begin
                        state_nxt = RD;
                        ld_go     = 1'b1;
                    end
                end
            end
            WR: begin
                if (pop) state_nxt = ((count > CNT_W'(1)) || push) ? WR : IDLE;
            end
            RD: begin
                if (bus_ack_v) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign sh_b = bus.bus_rdata >> {ld_lsb, 3'b000};
    assign sh_h = bus.bus_rdata >> {ld_lsb[1], 4'b0000};

    always_comb begin
        ld_data = bus.bus_rdata;
        case (ld_op)
            OP_LB, OP_LBU: ld_data = {24'b0, sh_b[7:0]};
            OP_LH, OP_LHU: ld_data = {16'b0, sh_h[15:0]};
            default:       ld_data = bus.bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            bus.bus_be    <= '0;
            ld_op         <= '0;
            ld_lsb        <= '0;
            mem_done      <= 1'b0;
            mem_rdata     <= '0;
            misalign      <= 1'b0;
            wb_overflow   <= 1'b0;
        end else begin
            if (state == IDLE && state_nxt == WR) begin
                bus.bus_req                                  <= 1'b1;
                bus.bus_we                                   <= 1'b1;
                {bus.bus_addr, bus.bus_wdata, bus.bus_be}    <= head;
            end else if (pop && state_nxt == WR) begin
                {bus.bus_addr, bus.bus_wdata, bus.bus_be}    <= head_next;
            end else if (ld_go) begin
                bus.bus_req  <= 1'b1;
                bus.bus_we   <= 1'b0;
                bus.bus_addr <= {mem_addr[31:2], 2'b00};
                bus.bus_be   <= 4'b1111;
                ld_op        <= opcode;
                ld_lsb       <= mem_addr[1:0];
            end else if (state_nxt == IDLE || state_nxt == DONE) begin
                bus.bus_req <= 1'b0;
                bus.bus_we  <= 1'b0;
            end

            mem_done  <= (state_nxt == DONE);
            mem_rdata <= (state == RD && bus_ack_v) ? ld_data : 32'h0;
            misalign  <= (mem_write && mis) || ld_mis;
            if (ovf_set) wb_overflow <= 1'b1;
        end
    end
endmodule
